// File: rtl/midi_parser_pkg.sv
// Shared MIDI definitions: parser state encoding, status byte constants and
// the data-length lookup used by the parser, router and transmit-side builder.
package midi_parser_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_D1 = 2'd1,
        S_WAIT_D2 = 2'd2,
        S_SYSEX   = 2'd3
    } state_t;

    localparam logic [3:0] NOTE_OFF     = 4'h8;
    localparam logic [3:0] NOTE_ON      = 4'h9;
    localparam logic [3:0] POLY_AT      = 4'hA;
    localparam logic [3:0] CTRL_CHANGE  = 4'hB;
    localparam logic [3:0] PROG_CHANGE  = 4'hC;
    localparam logic [3:0] CHAN_AT      = 4'hD;
    localparam logic [3:0] PITCH        = 4'hE;
    localparam logic [3:0] SYSTEM       = 4'hF;

    localparam logic [7:0] SYSEX_START  = 8'hF0;
    localparam logic [7:0] MTC_QFRAME   = 8'hF1;
    localparam logic [7:0] SONG_POS     = 8'hF2;
    localparam logic [7:0] SONG_SEL     = 8'hF3;
    localparam logic [7:0] TUNE_REQ     = 8'hF6;
    localparam logic [7:0] SYSEX_END    = 8'hF7;
    localparam logic [7:0] TIMING_CLOCK = 8'hF8;

    // Number of data bytes following a status byte (0 for single-byte or undefined).
    function automatic logic [1:0] midi_data_len(input logic [7:0] status);
        logic [1:0] len;
        len = 2'd0;
        case (status[7:4])
            NOTE_OFF, NOTE_ON, POLY_AT, CTRL_CHANGE, PITCH: len = 2'd2;
            PROG_CHANGE, CHAN_AT:                           len = 2'd1;
            SYSTEM: begin
                if (status == MTC_QFRAME || status == SONG_SEL) len = 2'd1;
                else if (status == SONG_POS)                    len = 2'd2;
            end
            default: len = 2'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/midi_parser.sv
// Assembles MIDI messages from a receiver byte stream into a one-entry output slot,
// with running status, realtime pass-through, SysEx streaming and partial-message timeout.
module midi_parser
    import midi_parser_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 120_000,
    parameter bit SYSEX_PASS     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxdv,
    input  logic [7:0] rxdata,
    output logic       msg_valid,
    input  logic       msg_ready,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic [1:0] msg_len,
    output logic       msg_sysex,
    output logic       overrun,
    output logic [7:0] drop_count,
    output logic [1:0] dbg_state
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    logic [7:0]       run_st_q, run_st_d;
    logic             run_valid_q, run_valid_d;
    logic [7:0]       cur_st_q, cur_st_d;
    logic             need2_q, need2_d;
    logic [6:0]       d1_q, d1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             valid_q, valid_d;
    logic [7:0]       status_q, status_d;
    logic [6:0]       data1_q, data1_d;
    logic [6:0]       data2_q, data2_d;
    logic [1:0]       len_q, len_d;
    logic             sysex_q, sysex_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       drop_q, drop_d;

    logic             emit;
    logic [7:0]       e_status;
    logic [6:0]       e_d1, e_d2;
    logic [1:0]       e_len;
    logic             e_sysex;

    always_comb begin
        state_d     = state_q;
        run_st_d    = run_st_q;
        run_valid_d = run_valid_q;
        cur_st_d    = cur_st_q;
        need2_d     = need2_q;
        d1_d        = d1_q;
        emit        = 1'b0;
        e_status    = 8'h00;
        e_d1        = 7'h00;
        e_d2        = 7'h00;
        e_len       = 2'd1;
        e_sysex     = 1'b0;

        if (rxdv || cnt_q == CNT_MAX) cnt_d = '0;
        else                          cnt_d = cnt_q + 1'b1;
        if (rxdv)                     cnt_d = '0;
        else if (cnt_q == CNT_MAX)    cnt_d = cnt_q;

        if (rxdv) begin
            if (rxdata >= TIMING_CLOCK) begin
                // Realtime bytes leave all parse state alone.
                emit     = 1'b1;
                e_status = rxdata;
            end else if (rxdata[7]) begin
                if (rxdata < SYSEX_START) begin
                    run_st_d    = rxdata;
                    run_valid_d = 1'b1;
                    cur_st_d    = rxdata;
                    need2_d     = (midi_data_len(rxdata) == 2'd2);
                    state_d     = S_WAIT_D1;
                end else begin
                    run_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    case (rxdata)
                        SYSEX_START: begin
                            state_d  = S_SYSEX;
                            emit     = SYSEX_PASS;
                            e_status = rxdata;
                            e_sysex  = 1'b1;
                        end
                        MTC_QFRAME, SONG_POS, SONG_SEL: begin
                            cur_st_d = rxdata;
                            need2_d  = (midi_data_len(rxdata) == 2'd2);
                            state_d  = S_WAIT_D1;
                        end
                        TUNE_REQ: begin
                            emit     = 1'b1;
                            e_status = rxdata;
                        end
                        SYSEX_END: begin
                            emit     = SYSEX_PASS && (state_q == S_SYSEX);
                            e_status = rxdata;
                            e_sysex  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (run_valid_q) begin
                            cur_st_d = run_st_q;
                            d1_d     = rxdata[6:0];
                            if (midi_data_len(run_st_q) == 2'd2) begin
                                need2_d = 1'b1;
                                state_d = S_WAIT_D2;
                            end else begin
                                need2_d  = 1'b0;
                                emit     = 1'b1;
                                e_status = run_st_q;
                                e_d1     = rxdata[6:0];
                                e_len    = 2'd2;
                            end
                        end
                    end
                    S_WAIT_D1: begin
                        d1_d = rxdata[6:0];
                        if (need2_q) begin
                            state_d = S_WAIT_D2;
                        end else begin
                            state_d  = S_IDLE;
                            emit     = 1'b1;
                            e_status = cur_st_q;
                            e_d1     = rxdata[6:0];
                            e_len    = 2'd2;
                        end
                    end
                    S_WAIT_D2: begin
                        state_d  = S_IDLE;
                        emit     = 1'b1;
                        e_status = cur_st_q;
                        e_d1     = d1_q;
                        e_d2     = rxdata[6:0];
                        e_len    = 2'd3;
                    end
                    S_SYSEX: begin
                        emit     = SYSEX_PASS;
                        e_status = rxdata;
                        e_sysex  = 1'b1;
                    end
                    default: ;
                endcase
            end
        end else if ((state_q == S_WAIT_D1 || state_q == S_WAIT_D2) && cnt_q == CNT_MAX) begin
            // Stale partial is discarded; running status survives.
            state_d = S_IDLE;
        end
    end

    // Slot handshake: a message transfers on a cycle where msg_valid && msg_ready;
    // while msg_valid is high without msg_ready, all fields hold steady.
    always_comb begin
        valid_d   = valid_q;
        status_d  = status_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        len_d     = len_q;
        sysex_d   = sysex_q;
        overrun_d = 1'b0;
        drop_d    = drop_q;

        if (emit) begin
            if (!valid_q || msg_ready) begin
                valid_d  = 1'b1;
                status_d = e_status;
                data1_d  = e_d1;
                data2_d  = e_d2;
                len_d    = e_len;
                sysex_d  = e_sysex;
            end else begin
                overrun_d = 1'b1;
                if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end
        end else if (valid_q && msg_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            run_st_q    <= 8'h00;
            run_valid_q <= 1'b0;
            cur_st_q    <= 8'h00;
            need2_q     <= 1'b0;
            d1_q        <= 7'h00;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            status_q    <= 8'h00;
            data1_q     <= 7'h00;
            data2_q     <= 7'h00;
            len_q       <= 2'd0;
            sysex_q     <= 1'b0;
            overrun_q   <= 1'b0;
            drop_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            run_st_q    <= run_st_d;
            run_valid_q <= run_valid_d;
            cur_st_q    <= cur_st_d;
            need2_q     <= need2_d;
            d1_q        <= d1_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            status_q    <= status_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            len_q       <= len_d;
            sysex_q     <= sysex_d;
            overrun_q   <= overrun_d;
            drop_q      <= drop_d;
        end
    end

    assign msg_valid  = valid_q;
    assign msg_status = status_q;
    assign msg_data1  = data1_q;
    assign msg_data2  = data2_q;
    assign msg_len    = len_q;
    assign msg_sysex  = sysex_q;
    assign overrun    = overrun_q;
    assign drop_count = drop_q;
    assign dbg_state  = state_q;

endmodule
